// File: rtl/data_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port data RAM.
// Each access takes three cycles: IDLE (arbitrate and latch the request),
// ACCESS (RAM cycle), and DONE (one-cycle ack to the granted master).
module data_ram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // master 0
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [3:0]    m0_sel,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  // master 1
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [3:0]    m1_sel,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  // data RAM
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [3:0]    ram_sel,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic          last_q;   // master granted most recently (0 = m0, 1 = m1)
  logic          gnt_q;    // master owning the current access
  logic          win;      // master that would win arbitration this cycle
  logic          req_any;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [3:0]    lat_sel;
  logic [DW-1:0] lat_wdata;

  // Round-robin winner: a lone requester wins; on a tie the master not granted last wins.
  always_comb begin
    req_any = m0_req | m1_req;
    if (m0_req && m1_req) win = ~last_q;
    else                  win = m1_req;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (which would infer a latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_any) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Grant pointer and request latch; both update only when an access is started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q    <= 1'b1;   // m1 counts as last granted, so m0 wins the first tie
      gnt_q     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_sel   <= '0;
      lat_wdata <= '0;
    end else if (state_q == IDLE && req_any) begin
      last_q    <= win;
      gnt_q     <= win;
      lat_we    <= win ? m1_we    : m0_we;
      lat_addr  <= win ? m1_addr  : m0_addr;
      lat_sel   <= win ? m1_sel   : m0_sel;
      lat_wdata <= win ? m1_wdata : m0_wdata;
    end
  end

  // Read data capture at the closing edge of ACCESS; writes leave rdata untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state_q == ACCESS && !lat_we) begin
      if (gnt_q) m1_rdata <= ram_rdata;
      else       m0_rdata <= ram_rdata;
    end
  end

  // Outputs decoded from state; rst forces IDLE at once, so ram_ce/ram_we drop before the next edge.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    busy      = (state_q != IDLE);
    if (state_q == ACCESS) begin
      ram_ce    = 1'b1;
      ram_we    = lat_we;
      ram_addr  = lat_addr;
      ram_sel   = lat_sel;
      ram_wdata = lat_wdata;
    end
    if (state_q == DONE) begin
      m0_ack = ~gnt_q;
      m1_ack = gnt_q;
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a byte-lane RAM model behind it.
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_sel = 0, m1_sel = 0;
  logic        m0_ack, m1_ack, ram_ce, ram_we, busy;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_ram_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  // RAM model: byte-lane writes on the rising edge, combinational read.
  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk)
    if (ram_ce && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
  assign ram_rdata = mem[ram_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_sel = sel; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_sel = sel; m1_wdata = wdata;
    end
  endtask

  // One complete transaction from IDLE; checks ack latency and that the FSM stays idle afterwards.
  task automatic txn(input string tag, input int m, input logic we, input logic [31:0] addr,
                     input logic [3:0] sel, input logic [31:0] wdata, output logic [31:0] rd);
    int  n = 0;
    bit  got = 0;
    rd = '0;
    @(negedge clk);
    drive(m, 1'b1, we, addr, sel, wdata);
    while (n < 10 && !got) begin
      @(posedge clk); #1;
      n++;
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
        got = 1;
        rd  = (m == 0) ? m0_rdata : m1_rdata;
      end
    end
    check({tag, "_latency"}, n, 2);
    drive(m, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 check({tag, "_idle_after"}, {31'd0, busy}, 0);
  endtask

  logic [31:0] rd;
  logic [11:0] a0, a1;
  int          ce_cnt, ack1_cnt;

  initial begin
    // Reset values.
    #3;
    check("rst_busy",   {31'd0, busy}, 0);
    check("rst_ram_ce", {31'd0, ram_ce}, 0);
    check("rst_acks",   {30'd0, m0_ack, m1_ack}, 0);
    check("rst_rdata",  m0_rdata | m1_rdata, 0);
    @(negedge clk) rst = 1'b0;

    // m0 write 0x10 with cycle-exact checks of the RAM interface.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("w_ram_ce",    {31'd0, ram_ce}, 1);
    check("w_ram_we",    {31'd0, ram_we}, 1);
    check("w_ram_addr",  ram_addr, 32'h10);
    check("w_ram_sel",   {28'd0, ram_sel}, 32'hF);
    check("w_ram_wdata", ram_wdata, 32'hDEADBEEF);
    check("w_busy",      {31'd0, busy}, 1);
    check("w_no_early_ack", {31'd0, m0_ack}, 0);
    @(posedge clk); #1;
    check("w_m0_ack",    {31'd0, m0_ack}, 1);
    check("w_m1_ack",    {31'd0, m1_ack}, 0);
    check("w_done_ram",  {ram_addr[30:0], ram_ce}, 0);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);

    // m1 reads it back; m0_rdata untouched by its own write.
    txn("m1_rd", 1, 1'b0, 32'h10, 4'hF, '0, rd);
    check("m1_rd_data",  rd, 32'hDEADBEEF);
    check("m0_rdata_unchanged", m0_rdata, 32'h0);

    // Mid-stream reset: pointer back to m1, rdata cleared.
    @(negedge clk) rst = 1'b1;
    #1 check("rst2_rdata", m1_rdata, 0);
    @(negedge clk) rst = 1'b0;

    // Both masters held: grants alternate m0, m1, m0, m1 three cycles apart.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h10, 4'hF, '0);
    drive(1, 1'b1, 1'b0, 32'h10, 4'hF, '0);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      a0[c-1] = m0_ack;
      a1[c-1] = m1_ack;
      if (c == 11) begin
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
      end
    end
    check("rr_m0_acks", {20'd0, a0}, 32'h082);
    check("rr_m1_acks", {20'd0, a1}, 32'h410);
    check("rr_m1_rdata", m1_rdata, 32'hDEADBEEF);
    repeat (2) @(posedge clk);

    // Partial-lane write merges into prior contents.
    txn("pre_wr", 0, 1'b1, 32'h20, 4'hF, 32'h11223344, rd);
    txn("lane_wr", 0, 1'b1, 32'h20, 4'b0010, 32'h0000AB00, rd);
    txn("lane_rd", 0, 1'b0, 32'h20, 4'hF, '0, rd);
    check("lane_rd_data", rd, 32'h1122AB44);
    check("lane_m1_rdata_kept", m1_rdata, 32'hDEADBEEF);

    // Reset during m1's ACCESS aborts the write and the ack.
    txn("seed30", 0, 1'b1, 32'h30, 4'hF, 32'h0BADF00D, rd);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h30, 4'hF, 32'h55AA55AA);
    @(posedge clk); #1;
    check("abort_in_access", {31'd0, ram_ce}, 1);
    #1 rst = 1'b1;
    #1;
    check("abort_ce_we", {30'd0, ram_ce, ram_we}, 0);
    check("abort_busy",  {31'd0, busy}, 0);
    check("abort_m0_rdata", m0_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    ack1_cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      ack1_cnt += m1_ack;
    end
    check("abort_no_ack", ack1_cnt, 0);
    txn("abort_rd", 0, 1'b0, 32'h30, 4'hF, '0, rd);
    check("abort_rd_data", rd, 32'h0BADF00D);

    // m1 pulses req only while m0 is in ACCESS: ignored and lost.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h20, 4'hF, '0);
    ce_cnt = 0; ack1_cnt = 0;
    @(posedge clk); #1;
    ce_cnt += ram_ce;
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF);
    @(posedge clk); #1;
    check("pulse_m0_ack", {31'd0, m0_ack}, 1);
    check("pulse_m0_rdata", m0_rdata, 32'h1122AB44);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (6) begin
      @(posedge clk); #1;
      ce_cnt   += ram_ce;
      ack1_cnt += m1_ack;
    end
    check("pulse_ce_count", ce_cnt, 1);
    check("pulse_no_m1_ack", ack1_cnt, 0);
    txn("pulse_rd", 1, 1'b0, 32'h20, 4'hF, '0, rd);
    check("pulse_rd_data", rd, 32'h1122AB44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
